// File: rtl/fft32_out_reorder.sv
// fft32_out_reorder: reorders one 32-bin FFT frame from MDC core output order
// into natural bin order through a ping-pong buffer.
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   start_i  - pulse with beat 0 of an input frame
//   dr_i/di_i - 4 lanes of real/imag input; beat b, lane l carries bin 8*l+b
//   dr_o/di_o - 4 lanes of real/imag output; beat j, lane l carries bin 4*j+l
//   valid_o, sop_o, eop_o - output framing (8-beat frames)
//   err_o    - sticky framing error, only when FFT32_REORDER_ERR_EN is defined,
//              otherwise tied low
// Sample width comes from the SFP_WIDTH macro (defaults to 16 here).
`ifndef SFP_WIDTH
`define SFP_WIDTH 16
`endif

module fft32_out_reorder (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [3:0][`SFP_WIDTH-1:0]  dr_i,
  input  logic [3:0][`SFP_WIDTH-1:0]  di_i,
  output logic [3:0][`SFP_WIDTH-1:0]  dr_o,
  output logic [3:0][`SFP_WIDTH-1:0]  di_o,
  output logic                        valid_o,
  output logic                        sop_o,
  output logic                        eop_o,
  output logic                        err_o
);

  localparam int unsigned SW    = `SFP_WIDTH;
  localparam int unsigned NBEAT = 8;
  localparam int unsigned NLANE = 4;
  localparam int unsigned NBIN  = 32;

  typedef enum logic {ST_IDLE, ST_READ} state_e;

  state_e          state_q, state_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic            wopen_q, wopen_d;
  logic            wbank_q, wbank_d;
  logic [1:0]      full_q, full_d;
  logic [2:0]      rcnt_q, rcnt_d;
  logic            rbank_q, rbank_d;
  logic [3:0][SW-1:0] dr_q, dr_d, di_q, di_d;
  logic            valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;

  logic [SW-1:0]   mem_re_q [2][NBIN];
  logic [SW-1:0]   mem_im_q [2][NBIN];

  logic            wr_en_c;
  logic [2:0]      wbeat_c;
  logic            wr_last_c;

  // Write side: start_i always restarts at beat 0 in the current bank.
  always_comb begin
    wr_en_c   = start_i | wopen_q;
    wbeat_c   = start_i ? 3'd0 : wcnt_q;
    wr_last_c = wr_en_c && (wbeat_c == 3'(NBEAT - 1));
    wcnt_d    = wcnt_q;
    wopen_d   = wopen_q;
    wbank_d   = wbank_q;
    if (start_i) begin
      wcnt_d  = 3'd1;
      wopen_d = 1'b1;
    end else if (wopen_q) begin
      wcnt_d  = wcnt_q + 3'd1;
      wopen_d = !wr_last_c;
    end
    if (wr_last_c) begin
      wbank_d = ~wbank_q;
    end
  end

  // Buffer storage; bin index is {lane, beat} on write.
  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      for (int l = 0; l < NLANE; l++) begin
        mem_re_q[wbank_q][{2'(l), wbeat_c}] <= dr_i[l];
        mem_im_q[wbank_q][{2'(l), wbeat_c}] <= di_i[l];
      end
    end
  end

  // Read FSM: a bank completing on the last read beat chains straight on.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    full_d  = full_q;
    valid_d = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    dr_d    = dr_q;
    di_d    = di_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_last_c) begin
          state_d = ST_READ;
          rcnt_d  = 3'd0;
          rbank_d = wbank_q;
        end else if (full_q != 2'b00) begin
          state_d = ST_READ;
          rcnt_d  = 3'd0;
          rbank_d = full_q[0] ? 1'b0 : 1'b1;
        end
      end
      ST_READ: begin
        valid_d = 1'b1;
        sop_d   = (rcnt_q == 3'd0);
        eop_d   = (rcnt_q == 3'(NBEAT - 1));
        for (int l = 0; l < NLANE; l++) begin
          dr_d[l] = mem_re_q[rbank_q][{rcnt_q, 2'(l)}];
          di_d[l] = mem_im_q[rbank_q][{rcnt_q, 2'(l)}];
        end
        rcnt_d = rcnt_q + 3'd1;
        if (rcnt_q == 3'(NBEAT - 1)) begin
          full_d[rbank_q] = 1'b0;
          rcnt_d          = 3'd0;
          if (wr_last_c) begin
            rbank_d = wbank_q;
          end else if (full_q[~rbank_q]) begin
            rbank_d = ~rbank_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A newly completed bank is marked after any release on the same cycle.
    if (wr_last_c) begin
      full_d[wbank_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 3'd0;
      wopen_q <= 1'b0;
      wbank_q <= 1'b0;
      full_q  <= 2'b00;
      rcnt_q  <= 3'd0;
      rbank_q <= 1'b0;
      dr_q    <= '0;
      di_q    <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      wopen_q <= wopen_d;
      wbank_q <= wbank_d;
      full_q  <= full_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
      dr_q    <= dr_d;
      di_q    <= di_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign dr_o    = dr_q;
  assign di_o    = di_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;

`ifdef FFT32_REORDER_ERR_EN
  logic err_q, err_d;

  // Short frame, or restart into the bank currently being replayed.
  always_comb begin
    err_d = err_q;
    if (start_i && (wopen_q ||
        (state_q == ST_READ && rbank_q == wbank_q && rcnt_q != 3'(NBEAT - 1)))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
